// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   INSTR_BYTES : bytes per fetched instruction (PC step)
//   fq_entry_t  : default fetch-queue record {pc, instr} for a 32-bit PC
//   if_cnt_w()  : width of a counter that must hold 0..n inclusive
package if_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int PKG_XLEN    = 32;

   typedef struct packed {
      logic [PKG_XLEN-1:0] pc;
      logic [31:0]         instr;
   } fq_entry_t;

   function automatic int if_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Fetch queue: synchronous FIFO of {pc, instr} records with wrap-around
// pointers (DEPTH is a power of two) and a flush that empties it in one cycle.
//   clk, rst_b          : clock, async active-low reset
//   flush               : drop all entries; has priority over enq/deq
//   enq_valid, enq_data : push one entry (accepted when not full, or full
//                         with a simultaneous pop)
//   deq_valid, deq_data : head entry, read straight from storage
//   deq_ready           : pop the head
//   count               : current occupancy 0..DEPTH
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fq_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = if_cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             flush,
   input  logic             enq_valid,
   input  entry_t           enq_data,
   input  logic             deq_ready,
   output logic             deq_valid,
   output entry_t           deq_data,
   output logic [CNT_W-1:0] count
);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_enq, do_deq;

   assign deq_valid = (count_q != '0);
   assign deq_data  = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      do_deq   = deq_valid && deq_ready;
      do_enq   = enq_valid && ((count_q != CNT_W'(DEPTH)) || do_deq);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_deq) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_enq, do_deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_enq && !flush) mem_q[wr_ptr_q] <= enq_data;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, pipelined imem
// requests under a credit limit, in-order response buffering and redirect
// squash of in-flight / queued instructions.
//   clk, rst_b                         : clock, async active-low reset
//   redirect_valid, redirect_pc        : redirect (low two PC bits ignored)
//   imem_req_valid/ready/addr          : fetch request channel
//   imem_resp_valid/data               : in-order fetch responses
//   fq_valid/ready, fq_pc, fq_instr    : head of fetch queue to decode
//   fetch_pc                           : next PC to request
// Build option IF_PERF_CNT_EN adds saturating counters perf_imem_stall
// (request stalled by imem) and perf_fq_full (queue full cycles).
module if_fetch_unit
   import if_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter int              FQ_DEPTH        = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   output logic            fq_valid,
   input  logic            fq_ready,
   output logic [XLEN-1:0] fq_pc,
   output logic [31:0]     fq_instr,
   output logic [XLEN-1:0] fetch_pc
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]     perf_imem_stall,
   output logic [31:0]     perf_fq_full
`endif
);

   localparam int OUT_W = if_cnt_w(MAX_OUTSTANDING);
   localparam int CNT_W = if_cnt_w(FQ_DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } entry_t;

   logic [XLEN-1:0]  pc_q, pc_d, resp_pc_q, resp_pc_d, redir_pc;
   logic [OUT_W-1:0] out_q, out_d, drop_q, drop_d;
   logic             active_q;
   logic [CNT_W-1:0] fq_count;
   logic             accept, resp_ok, enq;
   entry_t           enq_data, head;
   logic             unused_redir_lsb;

   assign redir_pc         = {redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redir_lsb = ^redirect_pc[1:0];

   always_comb begin
      // active_q keeps the request line low while reset is asserted and
      // for the first cycle after release.
      imem_req_valid = active_q && !redirect_valid
                    && (int'(out_q) < MAX_OUTSTANDING)
                    && (int'(out_q) + int'(fq_count) < FQ_DEPTH);
      accept    = imem_req_valid && imem_req_ready;
      // A response with nothing outstanding (e.g. stale, from before a
      // reset) is ignored outright.
      resp_ok   = imem_resp_valid && (out_q != '0);
      enq       = resp_ok && (drop_q == '0) && !redirect_valid;
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      drop_d    = drop_q;
      if (accept) pc_d = pc_q + XLEN'(INSTR_BYTES);
      case ({accept, resp_ok})
         2'b10:   out_d = out_q + 1'b1;
         2'b01:   out_d = out_q - 1'b1;
         default: out_d = out_q;
      endcase
      if (resp_ok && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (enq) resp_pc_d = resp_pc_q + XLEN'(INSTR_BYTES);
      if (redirect_valid) begin
         // Everything still in flight after this cycle's response belongs
         // to the squashed path.
         pc_d      = redir_pc;
         resp_pc_d = redir_pc;
         drop_d    = out_d;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         out_q     <= '0;
         drop_q    <= '0;
         active_q  <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         out_q     <= out_d;
         drop_q    <= drop_d;
         active_q  <= 1'b1;
      end
   end

   assign enq_data = '{pc: resp_pc_q, instr: imem_resp_data};

   if_fetch_queue #(
      .DEPTH   (FQ_DEPTH),
      .entry_t (entry_t)
   ) u_fq (
      .clk       (clk),
      .rst_b     (rst_b),
      .flush     (redirect_valid),
      .enq_valid (enq),
      .enq_data  (enq_data),
      .deq_ready (fq_ready),
      .deq_valid (fq_valid),
      .deq_data  (head),
      .count     (fq_count)
   );

   assign imem_req_addr = pc_q;
   assign fetch_pc      = pc_q;
   assign fq_pc         = head.pc;
   assign fq_instr      = head.instr;

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_q, stall_d, full_q, full_d;

   always_comb begin
      stall_d = stall_q;
      full_d  = full_q;
      if (imem_req_valid && !imem_req_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
      if ((fq_count == CNT_W'(FQ_DEPTH)) && (full_q != '1))     full_d  = full_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         stall_q <= '0;
         full_q  <= '0;
      end else begin
         stall_q <= stall_d;
         full_q  <= full_d;
      end
   end

   assign perf_imem_stall = stall_q;
   assign perf_fq_full    = full_q;
`endif

`ifndef SYNTHESIS
   // Armed only once this unit has issued a request since reset: responses
   // to pre-reset requests may still trickle in and are legitimately ignored.
   logic seen_q;
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)      seen_q <= 1'b0;
      else if (accept) seen_q <= 1'b1;
   end

   a_resp_without_req: assert property (@(posedge clk) disable iff (!rst_b)
      !(seen_q && imem_resp_valid && (out_q == '0)));
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        fq_valid;
   logic        fq_ready = 1'b0;
   logic [31:0] fq_pc;
   logic [31:0] fq_instr;
   logic [31:0] fetch_pc;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_imem_stall, perf_fq_full;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk             (clk),
      .rst_b           (rst_b),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .fq_valid        (fq_valid),
      .fq_ready        (fq_ready),
      .fq_pc           (fq_pc),
      .fq_instr        (fq_instr),
      .fetch_pc        (fetch_pc)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_imem_stall (perf_imem_stall),
      .perf_fq_full    (perf_fq_full)
`endif
   );

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        fqr;
      logic        e_v;
      logic [31:0] e_addr;
      logic        e_fv;
      logic [31:0] e_fpc;
      logic [31:0] e_fi;
   } vec_t;

   vec_t vecs[$];

   localparam logic [31:0] K = 32'h1000_0000;

   function automatic vec_t row(input logic rst, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic fqr, input logic e_v,
                                input logic [31:0] e_addr, input logic e_fv,
                                input logic [31:0] e_fpc, input logic [31:0] e_fi);
      vec_t r;
      r.rst = rst; r.rdy = rdy; r.rv = rv; r.rd = rd; r.fqr = fqr;
      r.e_v = e_v; r.e_addr = e_addr; r.e_fv = e_fv; r.e_fpc = e_fpc; r.e_fi = e_fi;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One cycle: drive just after the rising edge, sample on the falling edge.
   task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy,
                       input logic rv, input logic [31:0] rd, input logic fqr);
      @(posedge clk);
      #1;
      redirect_valid = redir; redirect_pc = rpc; imem_req_ready = rdy;
      imem_resp_valid = rv; imem_resp_data = rd; fq_ready = fqr;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; fq_ready = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
   endtask

   initial begin
      // Seq A: steady stream, 1-cycle latency, decode always ready.
      vecs.push_back(row(1, 0, 0, 0,      0, 0, 32'h0,  0, 32'h0, 32'h0));
      vecs.push_back(row(0, 1, 0, 0,      1, 1, 32'h0,  0, 0, 0));
      vecs.push_back(row(0, 1, 1, K,      1, 1, 32'h4,  0, 0, 0));
      vecs.push_back(row(0, 1, 1, K|32'h4,1, 1, 32'h8,  1, 32'h0, K));
      vecs.push_back(row(0, 1, 1, K|32'h8,1, 1, 32'hC,  1, 32'h4, K|32'h4));
      vecs.push_back(row(0, 0, 1, K|32'hC,1, 1, 32'h10, 1, 32'h8, K|32'h8));
      vecs.push_back(row(0, 0, 0, 0,      1, 1, 32'h10, 1, 32'hC, K|32'hC));
      // Seq B: decode stalled, queue fills to 4, then drains in order.
      vecs.push_back(row(1, 0, 0, 0,       0, 0, 32'h0,  0, 32'h0, 32'h0));
      vecs.push_back(row(0, 1, 0, 0,       0, 1, 32'h0,  0, 0, 0));
      vecs.push_back(row(0, 1, 1, K,       0, 1, 32'h4,  0, 0, 0));
      vecs.push_back(row(0, 1, 1, K|32'h4, 0, 1, 32'h8,  1, 32'h0, K));
      vecs.push_back(row(0, 1, 1, K|32'h8, 0, 1, 32'hC,  1, 32'h0, K));
      vecs.push_back(row(0, 1, 1, K|32'hC, 0, 0, 32'h10, 1, 32'h0, K));
      vecs.push_back(row(0, 1, 0, 0,       0, 0, 32'h10, 1, 32'h0, K));
      vecs.push_back(row(0, 1, 0, 0,       1, 0, 32'h10, 1, 32'h0, K));
      vecs.push_back(row(0, 1, 0, 0,       1, 1, 32'h10, 1, 32'h4, K|32'h4));
      vecs.push_back(row(0, 1, 1, K|32'h10,1, 1, 32'h14, 1, 32'h8, K|32'h8));
      vecs.push_back(row(0, 1, 1, K|32'h14,1, 1, 32'h18, 1, 32'hC, K|32'hC));
      vecs.push_back(row(0, 0, 1, K|32'h18,1, 1, 32'h1C, 1, 32'h10, K|32'h10));
      vecs.push_back(row(0, 0, 0, 0,       1, 1, 32'h1C, 1, 32'h14, K|32'h14));
      vecs.push_back(row(0, 0, 0, 0,       1, 1, 32'h1C, 1, 32'h18, K|32'h18));
      // Seq C: imem not ready for 5 cycles at 0x8.
      vecs.push_back(row(1, 0, 0, 0,      0, 0, 32'h0, 0, 32'h0, 32'h0));
      vecs.push_back(row(0, 1, 0, 0,      1, 1, 32'h0, 0, 0, 0));
      vecs.push_back(row(0, 1, 1, K,      1, 1, 32'h4, 0, 0, 0));
      vecs.push_back(row(0, 0, 1, K|32'h4,1, 1, 32'h8, 1, 32'h0, K));
      vecs.push_back(row(0, 0, 0, 0,      1, 1, 32'h8, 1, 32'h4, K|32'h4));
      vecs.push_back(row(0, 0, 0, 0,      1, 1, 32'h8, 0, 0, 0));
      vecs.push_back(row(0, 0, 0, 0,      1, 1, 32'h8, 0, 0, 0));
      vecs.push_back(row(0, 0, 0, 0,      1, 1, 32'h8, 0, 0, 0));
      vecs.push_back(row(0, 1, 0, 0,      1, 1, 32'h8, 0, 0, 0));
      vecs.push_back(row(0, 0, 1, K|32'h8,1, 1, 32'hC, 0, 0, 0));
      vecs.push_back(row(0, 0, 0, 0,      1, 1, 32'hC, 1, 32'h8, K|32'h8));

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         if (vecs[i].rst) rst_b = 1'b0;
         redirect_valid = 1'b0; redirect_pc = '0;
         imem_req_ready = vecs[i].rdy; imem_resp_valid = vecs[i].rv;
         imem_resp_data = vecs[i].rd;  fq_ready = vecs[i].fqr;
         @(negedge clk);
         chk($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_v));
         chk($sformatf("row%0d req_addr", i),  imem_req_addr, vecs[i].e_addr);
         chk($sformatf("row%0d fetch_pc", i),  fetch_pc,      vecs[i].e_addr);
         chk($sformatf("row%0d fq_valid", i),  32'(fq_valid), 32'(vecs[i].e_fv));
         if (vecs[i].e_fv || vecs[i].rst) begin
            chk($sformatf("row%0d fq_pc", i),    fq_pc,    vecs[i].e_fpc);
            chk($sformatf("row%0d fq_instr", i), fq_instr, vecs[i].e_fi);
         end
         if (vecs[i].rst) rst_b = 1'b1;
      end

      // Redirect to 0x100 (low bits set, ignored) with two requests in flight.
      do_reset();
      step(0, 0, 1, 0, 0, 1);              chk("rd1 addr0", imem_req_addr, 32'h0);
      step(0, 0, 1, 0, 0, 1);              chk("rd1 addr4", imem_req_addr, 32'h4);
      step(1, 32'h103, 1, 0, 0, 1);        chk("rd1 req_valid in redirect", 32'(imem_req_valid), 32'h0);
      step(0, 0, 0, 1, 32'hDEAD0000, 1);   chk("rd1 fetch_pc", fetch_pc, 32'h100);
                                           chk("rd1 fq_valid drop1", 32'(fq_valid), 32'h0);
      step(0, 0, 1, 1, 32'hDEAD0004, 1);   chk("rd1 addr 0x100", imem_req_addr, 32'h100);
                                           chk("rd1 req_valid after", 32'(imem_req_valid), 32'h1);
      step(0, 0, 0, 1, 32'h55550100, 1);   chk("rd1 fq_valid drop2", 32'(fq_valid), 32'h0);
      step(0, 0, 0, 0, 0, 1);              chk("rd1 fq_valid", 32'(fq_valid), 32'h1);
                                           chk("rd1 fq_pc", fq_pc, 32'h100);
                                           chk("rd1 fq_instr", fq_instr, 32'h55550100);

      // Redirect with a queued entry, two in flight and a response that same cycle.
      do_reset();
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 32'h11110000, 0);   chk("rd2 credit stop", 32'(imem_req_valid), 32'h0);
      step(0, 0, 1, 0, 0, 0);              chk("rd2 addr8", imem_req_addr, 32'h8);
                                           chk("rd2 fq_instr", fq_instr, 32'h11110000);
      step(1, 32'h200, 1, 1, 32'h11110004, 0);
                                           chk("rd2 req_valid in redirect", 32'(imem_req_valid), 32'h0);
                                           chk("rd2 fq_valid pre", 32'(fq_valid), 32'h1);
      step(0, 0, 1, 1, 32'hBAD00008, 0);   chk("rd2 flushed", 32'(fq_valid), 32'h0);
                                           chk("rd2 addr 0x200", imem_req_addr, 32'h200);
      step(0, 0, 0, 1, 32'h77770200, 0);   chk("rd2 fq_valid drop", 32'(fq_valid), 32'h0);
      step(0, 0, 0, 0, 0, 0);              chk("rd2 fq_pc", fq_pc, 32'h200);
                                           chk("rd2 fq_instr2", fq_instr, 32'h77770200);

      // Asynchronous reset mid-stream, then stale responses after release.
      do_reset();
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 32'h66000000, 0);
      step(0, 0, 1, 1, 32'h66000004, 0);
      step(0, 0, 1, 1, 32'h66000008, 0);   chk("rs fq_valid pre", 32'(fq_valid), 32'h1);
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      #2 rst_b = 1'b0;
      #1;
      chk("rs req_valid", 32'(imem_req_valid), 32'h0);
      chk("rs fq_valid", 32'(fq_valid), 32'h0);
      chk("rs fq_pc", fq_pc, 32'h0);
      chk("rs fq_instr", fq_instr, 32'h0);
      chk("rs fetch_pc", fetch_pc, 32'h0);
      @(negedge clk);
      @(negedge clk);
      imem_req_ready = 1'b0;
      rst_b = 1'b1;
      step(0, 0, 0, 1, 32'hBADBAD0C, 0);   chk("rs addr", imem_req_addr, 32'h0);
      step(0, 0, 0, 1, 32'hBADBAD10, 0);   chk("rs stale1", 32'(fq_valid), 32'h0);
      step(0, 0, 1, 0, 0, 0);              chk("rs stale2", 32'(fq_valid), 32'h0);
                                           chk("rs first req", 32'(imem_req_valid), 32'h1);
      step(0, 0, 0, 1, 32'h66660000, 0);
      step(0, 0, 0, 0, 0, 0);              chk("rs fq_valid post", 32'(fq_valid), 32'h1);
                                           chk("rs fq_pc post", fq_pc, 32'h0);
                                           chk("rs fq_instr post", fq_instr, 32'h66660000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
